lsq_mem_unit: RTL



---
 rtl/lsq_mem_unit_pkg.sv | 30 +++
 rtl/lsq_mem_unit_byte_fmt.sv | 30 +++
 rtl/lsq_mem_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsq_mem_unit_pkg.sv
// Shared types and constants for the load/store queue: the per-entry record,
// the issue FSM encoding and the decoder opcode/funct3 values it serves.
package lsq_mem_unit_pkg;

  localparam int unsigned LSQ_XLEN  = 32;
  localparam int unsigned LSQ_TAG_W = 4;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } lsq_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 addr_ok;
    logic                 is_load;
    logic                 is_store;
    logic                 is_byte;
    logic [LSQ_TAG_W-1:0] tag;
    logic [LSQ_XLEN-1:0]  addr;
    logic [LSQ_XLEN-1:0]  data;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_mem_unit_byte_fmt.sv
// Byte-lane formatting: enables, SB lane replication and LB extraction with
// sign extension, all keyed off the low address bits.
module lsq_byte_fmt #(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic            is_byte,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] st_lanes,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0] sel;

  always_comb begin
    sel = ld_raw[{addr_lo, 3'b000} +: 8];
    if (is_byte) begin
      be       = 4'b0001 << addr_lo;
      st_lanes = {(XLEN/8){st_data[7:0]}};
      ld_data  = {{(XLEN-8){sel[7]}}, sel};
    end else begin
      be       = 4'b1111;
      st_lanes = st_data;
      ld_data  = ld_raw;
    end
  end

endmodule

// File: rtl/lsq_mem_unit.sv
// In-order load/store queue: tag-matched AGU capture, head-only issue to the
// data-memory port, stores gated on being the oldest ROB entry.
module lsq_mem_unit
  import lsq_mem_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_is_load,
  input  logic             disp_is_store,
  input  logic             disp_is_byte,
  input  logic             disp_is_word,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             agu_valid,
  input  logic [TAG_W-1:0] agu_tag,
  input  logic [XLEN-1:0]  agu_addr,
  input  logic [XLEN-1:0]  agu_data,
  input  logic [TAG_W-1:0] rob_head_tag,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [XLEN-1:0]  wb_data,
  output logic             empty
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  lsq_state_e       state_q, state_d;
  lsq_entry_t       ent_q [DEPTH];
  lsq_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;

  lsq_entry_t       head_ent;
  logic             head_elig, pop, load_done, disp_acc;
  logic [3:0]       fmt_be;
  logic [XLEN-1:0]  fmt_wdata, fmt_rdata;

  assign head_ent   = ent_q[head_q];
  assign head_elig  = head_ent.valid && head_ent.addr_ok &&
                      (head_ent.is_load || (head_ent.is_store && head_ent.tag == rob_head_tag));
  assign disp_ready = (count_q != FULL_CNT);
  assign empty      = (count_q == '0);
  assign disp_acc   = disp_valid && disp_ready && (disp_is_load || disp_is_store);
  assign wb_valid   = wb_valid_q;
  assign wb_tag     = wb_tag_q;
  assign wb_data    = wb_data_q;

  lsq_byte_fmt #(.XLEN(XLEN)) u_fmt (
    .addr_lo  (head_ent.addr[1:0]),
    .is_byte  (head_ent.is_byte),
    .st_data  (head_ent.data),
    .ld_raw   (mem_rdata),
    .be       (fmt_be),
    .st_lanes (fmt_wdata),
    .ld_data  (fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      ST_IDLE: if (head_elig) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ready) begin
          if (head_ent.is_store) begin
            state_d = ST_IDLE;
            pop     = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d   = ST_IDLE;
          pop       = 1'b1;
          load_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      pop       = 1'b0;
      load_done = 1'b0;
    end
  end

  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req && head_ent.is_store;
    mem_addr  = mem_req ? {head_ent.addr[XLEN-1:2], 2'b00} : '0;
    mem_be    = mem_req ? fmt_be : '0;
    mem_wdata = mem_req ? fmt_wdata : '0;
  end

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wb_valid_d = 1'b0;
    wb_tag_d   = wb_tag_q;
    wb_data_d  = wb_data_q;
    if (agu_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && ent_q[i].tag == agu_tag) begin
          ent_d[i].addr    = agu_addr;
          ent_d[i].data    = agu_data;
          ent_d[i].addr_ok = 1'b1;
        end
      end
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end
    if (load_done) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = head_ent.tag;
      wb_data_d  = fmt_rdata;
    end
    if (disp_acc) begin
      ent_d[tail_q] = '{valid: 1'b1, addr_ok: 1'b0, is_load: disp_is_load,
                        is_store: disp_is_store, is_byte: disp_is_byte & ~disp_is_word,
                        tag: disp_tag, addr: '0, data: '0};
      tail_d = tail_q + 1'b1;
    end
    unique case ({disp_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule
